// File: rtl/pc_disparo.sv
// pc_disparo: computer-side shooter for the 5x5 Battleship board.
//
// On each turn (start pulse) it searches a pseudo-random cell not yet fired
// at, fires at it, checks the player's ship map and reports hit or miss.
// A sticky victoria_pc flag rises once every player ship cell has been hit.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   clear         synchronous new-game clear (shot map, hit count, flags)
//   start         one-cycle pulse: begin PC turn (ignored while busy)
//   ocupadas      player ship map, bit i = ship piece in cell i
//   casilla       cell last fired at, held until the next shot
//   disparo_valid one-cycle pulse in the firing cycle
//   impacto/agua  one-cycle pulses with done: hit / miss
//   done          one-cycle pulse: turn finished
//   agotado       one-cycle pulse with done: no cell left, no shot made
//   victoria_pc   sticky: all ship cells hit
//   num_impactos  hits this game, saturating at N_CASILLAS
module pc_disparo #(
    parameter int         N_CASILLAS = 25,
    parameter logic [4:0] SEED       = 5'b00001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic [N_CASILLAS-1:0] ocupadas,
    output logic [4:0]            casilla,
    output logic                  disparo_valid,
    output logic                  impacto,
    output logic                  agua,
    output logic                  done,
    output logic                  agotado,
    output logic                  victoria_pc,
    output logic [4:0]            num_impactos
);

    typedef enum logic [1:0] {IDLE, BUSCAR, DISPARAR, REPORTAR} state_t;

    state_t                state, state_nx;
    logic [4:0]            lfsr;
    logic [4:0]            cand;
    logic [4:0]            lfsr_m1;
    logic [N_CASILLAS-1:0] shot_map;
    logic                  hit_r;
    logic                  agot_r;
    logic                  elegible;
    logic                  lleno;
    logic                  hit_now;

    // 32-bit views so any 5-bit index is in range; cells past the board read
    // as already fired / empty.
    logic [31:0]           shot_ext;
    logic [31:0]           ocup_ext;
    logic [31:0]           cand_bit;

    assign shot_ext = {{(32-N_CASILLAS){1'b1}}, shot_map};
    assign ocup_ext = {{(32-N_CASILLAS){1'b0}}, ocupadas};
    assign cand_bit = 32'd1 << cand;
    assign lfsr_m1  = lfsr - 5'd1;
    assign elegible = (lfsr <= 5'(N_CASILLAS)) && !shot_ext[lfsr_m1];
    assign lleno    = &shot_map;
    assign hit_now  = ocup_ext[cand];

    // Free-running x^5+x^3+1 LFSR; clear deliberately leaves it alone so a
    // new game does not replay the previous shot order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= SEED;
        else      lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = BUSCAR;
            BUSCAR: begin
                if (lleno)         state_nx = REPORTAR;
                else if (elegible) state_nx = DISPARAR;
            end
            DISPARAR: state_nx = REPORTAR;
            REPORTAR: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand         <= '0;
            casilla      <= '0;
            shot_map     <= '0;
            hit_r        <= 1'b0;
            agot_r       <= 1'b0;
            num_impactos <= '0;
            victoria_pc  <= 1'b0;
        end else if (clear) begin
            shot_map     <= '0;
            hit_r        <= 1'b0;
            agot_r       <= 1'b0;
            num_impactos <= '0;
            victoria_pc  <= 1'b0;
        end else begin
            case (state)
                BUSCAR: begin
                    agot_r <= lleno;
                    if (!lleno && elegible) cand <= lfsr_m1;
                end
                DISPARAR: begin
                    casilla  <= cand;
                    shot_map <= shot_map | cand_bit[N_CASILLAS-1:0];
                    hit_r    <= hit_now;
                    if (hit_now && num_impactos != 5'(N_CASILLAS))
                        num_impactos <= num_impactos + 5'd1;
                end
                REPORTAR: begin
                    // shot_map already includes this turn's cell
                    if (ocupadas != '0 && (ocupadas & ~shot_map) == '0)
                        victoria_pc <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pulses decode the state register only, so reset clears them at once.
    assign disparo_valid = (state == DISPARAR);
    assign done          = (state == REPORTAR);
    assign impacto       = done &  hit_r & ~agot_r;
    assign agua          = done & ~hit_r & ~agot_r;
    assign agotado       = done &  agot_r;

endmodule

// File: doc/pc_disparo.md
Name: pc_disparo

Overview:
- Computer-side shooter for the 5x5 Battleship board. It is the counterpart of the player's shot path.
- On each PC turn it picks a pseudo-random cell not yet fired at and fires at it. It then checks the cell against the player's ship-occupancy map and reports hit or miss.
- It tracks every shot and raises a sticky PC-victory flag once all player ship cells are hit.
- Sits between the game FSM (turn pulse in; done, hit and victory out) and the player ship registers (occupancy map in).

Parameters:
- N_CASILLAS, 25, number of board cells; valid indices 0..N_CASILLAS-1 (must be ≤31).
- SEED, 5'b00001, LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous new-game clear of shot map and flags.
- start  input  1  one-cycle pulse from FSM: begin PC turn.
- ocupadas  input  25  player ship map; bit i=1 means cell i holds a ship piece. Sampled in DISPARAR.
- casilla  output  5  cell fired at; held until next shot.
- disparo_valid  output  1  one-cycle pulse when casilla is updated.
- impacto  output  1  one-cycle pulse with done: shot hit a ship.
- agua  output  1  one-cycle pulse with done: shot missed.
- done  output  1  one-cycle pulse: turn finished.
- agotado  output  1  one-cycle pulse with done: no cell left, no shot made.
- victoria_pc  output  1  sticky: all ship cells hit.
- num_impactos  output  5  count of hits this game, saturating at 25.

Behaviour:
- Reset (rst=0, async) sets the following immediately:
  - state=IDLE, lfsr=SEED, shot map=0.
  - casilla=0, num_impactos=0, victoria_pc=0.
  - All pulses (disparo_valid, impacto, agua, done, agotado) = 0.
- LFSR:
  - 5-bit Fibonacci, x^5+x^3+1, next = {lfsr[3:0], lfsr[4]^lfsr[2]}.
  - Advances every clock while rst=1, in every state.
  - Period 31, never zero.
- Candidate cell = lfsr-1. A candidate is eligible iff lfsr ≤ N_CASILLAS and the shot-map bit is 0.
- FSM states, one transition per clock:
  - IDLE: start=1 → BUSCAR. start in any other state is ignored (no queuing).
  - BUSCAR:
    - If the shot map is all ones → REPORTAR with agotado set.
    - Else if the candidate is eligible → latch the candidate into a cand register, go to DISPARAR.
    - Else stay in BUSCAR.
    - Guaranteed exit within 31 cycles.
  - DISPARAR:
    - casilla<=cand; disparo_valid=1 this cycle; set shot-map bit cand.
    - hit_r <= ocupadas[cand].
    - If hit, num_impactos <= num_impactos+1 (saturating).
    - → REPORTAR.
  - REPORTAR:
    - done=1.
    - impacto=hit_r and agua=~hit_r, unless agotado (then both 0, agotado=1).
    - victoria_pc <= 1 if ocupadas≠0 and (ocupadas & ~shotmap_updated)==0.
    - → IDLE.
- Latency: start to done is 3 cycles minimum, 33 cycles maximum.
- Each cell is fired at most once per game; 25 turns cover all cells exactly once.
- victoria_pc:
  - Sticky; cleared only by rst or clear.
  - Never set when ocupadas=0.
  - Updates continue after victory; FSM is expected to stop issuing start.
- clear:
  - Returns to IDLE; zeros shot map, num_impactos, victoria_pc and all pulses.
  - Does not reset the LFSR.
  - Has priority over start in the same cycle.
- Reset mid-turn: aborts with no done pulse; next start begins fresh.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Hit path: rst release, ocupadas=25'h1FFFFFF, start.
  - Required: disparo_valid exactly once, casilla<25.
  - done with impacto=1, agua=0; num_impactos=1; victoria_pc=0.
- Full coverage and victory: ocupadas=25'h1FFFFFF, 25 starts each waiting for done.
  - Required: 25 distinct casilla values 0..24, all impacto.
  - num_impactos=25; victoria_pc rises in the REPORTAR cycle of turn 25 only.
- Exhaustion: continue with a 26th start.
  - Required: done with agotado=1, impacto=agua=0.
  - No disparo_valid; casilla unchanged.
- All misses: ocupadas=0, 25 turns.
  - Required: every done has agua=1; num_impactos=0; victoria_pc stays 0.
- Partial fleet: ocupadas=25'h0000007 (cells 0..2).
  - Required: victoria_pc asserts exactly at the turn when the third of cells 0..2 is fired.
  - num_impactos=3 at that point.
- Reset and clear:
  - rst=0 asynchronously while in BUSCAR: all outputs 0 without a clock edge, and no done pulse afterwards.
  - clear after 10 turns: next 25 turns cover all 25 cells again.
  - start asserted while busy: no extra shot.
